adder_arbiter_16: RTL and testbench

ADDER_ARBITER_16 -- requirements
Module: adder_arbiter_16

---
 rtl/adder_arbiter_16.sv | 121 ++++++++++++
 tb/tb_adder_arbiter_16.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter_16.sv
// Two-requester 16-bit add/subtract unit with one shared adder and a
// one-entry result register.
// Ties between the requesters are resolved by round-robin arbitration.
module adder_arbiter_16 #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [15:0]      req0_a,
  input  logic [15:0]      req0_b,
  input  logic             req0_sub,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [15:0]      req1_a,
  input  logic [15:0]      req1_b,
  input  logic             req1_sub,
  output logic             req1_ready,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [15:0]      result,
  output logic             carry,
  output logic             overflow,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t             state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic [15:0]        result_q, result_d;
  logic               carry_q, carry_d;
  logic               overflow_q, overflow_d;
  logic               resp_id_q, resp_id_d;
  logic [CNT_W-1:0]   cnt0_q, cnt0_d;
  logic [CNT_W-1:0]   cnt1_q, cnt1_d;

  logic               open_slot;
  logic               grant0;
  logic               grant1;
  logic               accept;
  logic [15:0]        op_a;
  logic [15:0]        op_b;
  logic               op_sub;
  logic [15:0]        b_eff;
  logic [16:0]        sum;

  // A requester wins if it is alone, or if the other one was granted last.
  always_comb begin
    open_slot = (state_q == EMPTY) || resp_ready;
    grant0    = !reset && open_slot && req0_valid && (!req1_valid || last_grant_q);
    grant1    = !reset && open_slot && req1_valid && (!req0_valid || !last_grant_q);
    accept    = grant0 || grant1;
  end

  always_comb begin
    op_a   = grant1 ? req1_a   : req0_a;
    op_b   = grant1 ? req1_b   : req0_b;
    op_sub = grant1 ? req1_sub : req0_sub;
    b_eff  = op_b ^ {16{op_sub}};
    sum    = {1'b0, op_a} + {1'b0, b_eff} + {16'b0, op_sub};
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    result_d     = result_q;
    carry_d      = carry_q;
    overflow_d   = overflow_q;
    resp_id_d    = resp_id_q;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;
    if (accept) begin
      state_d      = FULL;
      last_grant_d = grant1;
      resp_id_d    = grant1;
      result_d     = sum[15:0];
      carry_d      = sum[16];
      overflow_d   = (op_a[15] == b_eff[15]) && (sum[15] != op_a[15]);
      if (grant1) cnt1_d = cnt1_q + 1'b1;
      else        cnt0_d = cnt0_q + 1'b1;
    end else if (state_q == FULL && resp_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= EMPTY;
      last_grant_q <= 1'b1;
      result_q     <= '0;
      carry_q      <= 1'b0;
      overflow_q   <= 1'b0;
      resp_id_q    <= 1'b0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      result_q     <= result_d;
      carry_q      <= carry_d;
      overflow_q   <= overflow_d;
      resp_id_q    <= resp_id_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign resp_valid = (state_q == FULL);
  assign resp_id    = resp_id_q;
  assign result     = result_q;
  assign carry      = carry_q;
  assign overflow   = overflow_q;
  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;

endmodule

// File: tb/tb_adder_arbiter_16.sv
// Directed bench for adder_arbiter_16: an arithmetic vector table plus
// sequences for fairness, backpressure, reset and counter wrap.
module tb_adder_arbiter_16;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_sub, req1_sub;
  logic        req0_ready, req1_ready;
  logic        resp_valid, resp_ready, resp_id;
  logic [15:0] result;
  logic        carry, overflow;
  logic [7:0]  grant_cnt0, grant_cnt1;

  logic        w_reset, w_valid, w_ready0, w_ready1, w_resp_valid, w_resp_id;
  logic        w_carry, w_overflow;
  logic [15:0] w_result;
  logic [1:0]  w_cnt0, w_cnt1;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] exp_result;
    logic        exp_carry;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  adder_arbiter_16 #(.CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .req1_ready(req1_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .result(result), .carry(carry), .overflow(overflow),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  adder_arbiter_16 #(.CNT_W(2)) dut_wrap (
    .clk(clk), .reset(w_reset),
    .req0_valid(w_valid), .req0_a(16'h0001), .req0_b(16'h0002), .req0_sub(1'b0),
    .req0_ready(w_ready0),
    .req1_valid(1'b0), .req1_a(16'h0000), .req1_b(16'h0000), .req1_sub(1'b0),
    .req1_ready(w_ready1),
    .resp_valid(w_resp_valid), .resp_ready(1'b1), .resp_id(w_resp_id),
    .result(w_result), .carry(w_carry), .overflow(w_overflow),
    .grant_cnt0(w_cnt0), .grant_cnt1(w_cnt1)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [15:0] a0, input logic [15:0] b0, input logic s0,
                               input logic v1, input logic [15:0] a1, input logic [15:0] b1, input logic s1,
                               input logic rr);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_sub = s0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_sub = s1;
    resp_ready = rr;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{16'h0005, 16'h0003, 1'b0, 16'h0008, 1'b0, 1'b0};
    vecs[1] = '{16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0};
    vecs[2] = '{16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[5] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[6] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};

    reset = 1'b1;
    w_reset = 1'b1;
    w_valid = 1'b0;
    applyStimulus(1'b1, 16'h0, 16'h0, 1'b0, 1'b1, 16'h0, 16'h0, 1'b0, 1'b1);

    // Reset for two cycles; readies must stay low even with both valids up.
    step();
    #1;
    checkOutput("ready0_in_reset", req0_ready, 1'b0);
    checkOutput("ready1_in_reset", req1_ready, 1'b0);
    step();
    reset = 1'b0;
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    step();
    checkOutput("rst_resp_valid", resp_valid, 1'b0);
    checkOutput("rst_result", result, 16'h0);
    checkOutput("rst_carry", carry, 1'b0);
    checkOutput("rst_overflow", overflow, 1'b0);
    checkOutput("rst_resp_id", resp_id, 1'b0);
    checkOutput("rst_cnt0", grant_cnt0, 8'd0);
    checkOutput("rst_cnt1", grant_cnt1, 8'd0);
    req0_valid = 1'b1;
    #1;
    checkOutput("idle_ready0", req0_ready, 1'b1);
    checkOutput("idle_ready1", req1_ready, 1'b0);
    req0_valid = 1'b0;
    #1;
    checkOutput("idle_ready0_novalid", req0_ready, 1'b0);

    // Arithmetic table, issued back to back on requester 0.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, vecs[i].a, vecs[i].b, vecs[i].sub, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      #1;
      checkOutput($sformatf("vec%0d_ready0", i), req0_ready, 1'b1);
      step();
      checkOutput($sformatf("vec%0d_resp_valid", i), resp_valid, 1'b1);
      checkOutput($sformatf("vec%0d_result", i), result, vecs[i].exp_result);
      checkOutput($sformatf("vec%0d_carry", i), carry, vecs[i].exp_carry);
      checkOutput($sformatf("vec%0d_overflow", i), overflow, vecs[i].exp_ovf);
      checkOutput($sformatf("vec%0d_resp_id", i), resp_id, 1'b0);
    end
    req0_valid = 1'b0;
    step();
    checkOutput("drain_resp_valid", resp_valid, 1'b0);
    checkOutput("drain_result_hold", result, 16'h5555);
    checkOutput("table_cnt0", grant_cnt0, 8'd7);

    // Fairness from a fresh reset: requester 0 wins the first tie, then alternate.
    reset = 1'b1;
    step();
    reset = 1'b0;
    applyStimulus(1'b1, 16'd1, 16'd1, 1'b0, 1'b1, 16'd10, 16'd20, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      #1;
      checkOutput($sformatf("fair%0d_ready0", i), req0_ready, (i % 2 == 0));
      checkOutput($sformatf("fair%0d_ready1", i), req1_ready, (i % 2 == 1));
      step();
      checkOutput($sformatf("fair%0d_resp_valid", i), resp_valid, 1'b1);
      checkOutput($sformatf("fair%0d_resp_id", i), resp_id, (i % 2 == 1));
      checkOutput($sformatf("fair%0d_result", i), result, (i % 2 == 0) ? 16'd2 : 16'd30);
    end
    checkOutput("fair_cnt0", grant_cnt0, 8'd3);
    checkOutput("fair_cnt1", grant_cnt1, 8'd3);

    // Backpressure: result from requester 1 (30) is held while resp_ready is low.
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 16'd100, 16'd1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput($sformatf("bp%0d_ready0", i), req0_ready, 1'b0);
      checkOutput($sformatf("bp%0d_ready1", i), req1_ready, 1'b0);
      step();
      checkOutput($sformatf("bp%0d_resp_valid", i), resp_valid, 1'b1);
      checkOutput($sformatf("bp%0d_result", i), result, 16'd30);
      checkOutput($sformatf("bp%0d_resp_id", i), resp_id, 1'b1);
    end
    resp_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready1", req1_ready, 1'b1);
    step();
    checkOutput("bp_new_resp_valid", resp_valid, 1'b1);
    checkOutput("bp_new_result", result, 16'd99);
    checkOutput("bp_new_resp_id", resp_id, 1'b1);
    checkOutput("bp_cnt1", grant_cnt1, 8'd4);
    req1_valid = 1'b0;
    step();
    checkOutput("bp_consume_resp_valid", resp_valid, 1'b0);
    checkOutput("bp_consume_result_hold", result, 16'd99);

    // In EMPTY a low resp_ready must not block acceptance.
    applyStimulus(1'b1, 16'h00F0, 16'h000F, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    #1;
    checkOutput("empty_ready0_rr0", req0_ready, 1'b1);
    step();
    checkOutput("empty_accept_result", result, 16'h00FF);
    checkOutput("empty_accept_valid", resp_valid, 1'b1);

    // Reset while FULL and stalled discards the result; the next tie goes to req0.
    applyStimulus(1'b1, 16'd7, 16'd7, 1'b0, 1'b1, 16'd9, 16'd9, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    checkOutput("midrst_ready0", req0_ready, 1'b0);
    checkOutput("midrst_ready1", req1_ready, 1'b0);
    step();
    reset = 1'b0;
    checkOutput("midrst_resp_valid", resp_valid, 1'b0);
    checkOutput("midrst_result", result, 16'h0);
    checkOutput("midrst_cnt0", grant_cnt0, 8'd0);
    checkOutput("midrst_cnt1", grant_cnt1, 8'd0);
    #1;
    checkOutput("midrst_tie_ready0", req0_ready, 1'b1);
    checkOutput("midrst_tie_ready1", req1_ready, 1'b0);
    step();
    checkOutput("midrst_tie_result", result, 16'd14);
    checkOutput("midrst_tie_id", resp_id, 1'b0);
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);

    // Two-bit counter wraps after four grants.
    w_reset = 1'b0;
    w_valid = 1'b1;
    for (int i = 0; i < 5; i++) step();
    w_valid = 1'b0;
    checkOutput("wrap_cnt0", w_cnt0, 2'd1);
    checkOutput("wrap_cnt1", w_cnt1, 2'd0);
    checkOutput("wrap_result", w_result, 16'd3);
    step();
    checkOutput("wrap_cnt0_idle", w_cnt0, 2'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
